// File: rtl/set_bit_serializer.sv
// set_bit_serializer: enumerates the set bits of a bitset, lowest index first,
// one index per output beat. An all-zero bitset yields one empty marker beat.
module set_bit_serializer #(
  parameter int ORDER = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<ORDER)-1:0] inBitset,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [ORDER-1:0]      outIndex,
  output logic [ORDER:0]        outOrdinal,
  output logic                  outLast,
  output logic                  outEmpty,
  output logic                  outValid,
  input  logic                  outReady
);

  localparam int N = 1 << ORDER;
  localparam logic [N-1:0] ONE_N   = 1;
  localparam logic [ORDER:0] ORD_ONE = 1;

  // one-bit state so outValid is the state flop itself
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   mask;
  logic [N-1:0]   src, rest;
  logic [ORDER-1:0] lsb_idx;
  logic           load, adv, done;

  // lowest set bit wins; zero input maps to index 0
  function automatic logic [ORDER-1:0] lsb_of(input logic [N-1:0] v);
    lsb_of = '0;
    for (int i = N-1; i >= 0; i--)
      if (v[i]) lsb_of = i[ORDER-1:0];
  endfunction

  // fresh bitset on accept, remaining bits while emitting
  assign src     = (state == IDLE) ? inBitset : mask;
  assign lsb_idx = lsb_of(src);
  assign rest    = src & (src - ONE_N);

  assign inReady  = (state == IDLE);
  assign outValid = (state == EMIT);

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // next state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (inValid) begin
        load      = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: if (outReady) begin
        if (outLast) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // beat registers; hold whenever no strobe fires (covers stalls)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask       <= '0;
      outIndex   <= '0;
      outOrdinal <= '0;
      outLast    <= 1'b0;
      outEmpty   <= 1'b0;
    end else if (load) begin
      mask       <= rest;
      outIndex   <= lsb_idx;
      outOrdinal <= '0;
      outLast    <= (rest == '0);
      outEmpty   <= (src == '0);
    end else if (adv) begin
      mask       <= rest;
      outIndex   <= lsb_idx;
      outOrdinal <= outOrdinal + ORD_ONE;
      outLast    <= (rest == '0);
    end else if (done) begin
      outLast    <= 1'b0;
      outEmpty   <= 1'b0;
    end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed and randomized checks of set_bit_serializer at ORDER=7; small
// bitsets are zero-extended so the 8-bit vectors keep their indices.
module tb_set_bit_serializer;
  localparam int ORDER = 7;
  localparam int N = 1 << ORDER;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     inBitset = '0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [ORDER-1:0] outIndex;
  logic [ORDER:0]   outOrdinal;
  logic             outLast, outEmpty, outValid;
  logic             outReady = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  set_bit_serializer #(.ORDER(ORDER)) dut (
    .clk(clk), .rst_n(rst_n), .inBitset(inBitset), .inValid(inValid),
    .inReady(inReady), .outIndex(outIndex), .outOrdinal(outOrdinal),
    .outLast(outLast), .outEmpty(outEmpty), .outValid(outValid),
    .outReady(outReady)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"},   32'(outValid),   0);
    chk({tag, ".inready"}, 32'(inReady),    1);
    chk({tag, ".last"},    32'(outLast),    0);
    chk({tag, ".empty"},   32'(outEmpty),   0);
  endtask

  // present a bitset at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [N-1:0] b);
    int n = 0;
    while (!inReady && n < 300) begin @(negedge clk); n++; end
    chk("send.ready", 32'(inReady), 1);
    inValid  = 1'b1;
    inBitset = b;
    @(negedge clk);
    inValid  = 1'b0;
    inBitset = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // check the beat on display now, then advance one cycle
  task automatic beat(input string tag, input int idx, input int ord, input bit last, input bit empty);
    chk({tag, ".valid"}, 32'(outValid),   1);
    chk({tag, ".index"}, 32'(outIndex),   32'(idx));
    chk({tag, ".ord"},   32'(outOrdinal), 32'(ord));
    chk({tag, ".last"},  32'(outLast),    32'(last));
    chk({tag, ".empty"}, 32'(outEmpty),   32'(empty));
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] b;
    int exp_idx[$];
    int k, cyc;
    bit fin;

    // reset values, during and after reset
    @(negedge clk);
    chk_idle("rst");
    chk("rst.index", 32'(outIndex), 0);
    chk("rst.ord",   32'(outOrdinal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // 8'b1010_0100 streams 2,5,7 back to back
    outReady = 1'b1;
    send(N'(8'hA4));
    beat("a4_0", 2, 0, 0, 0);
    beat("a4_1", 5, 1, 0, 0);
    beat("a4_2", 7, 2, 1, 0);
    chk_idle("a4_done");

    // empty bitset: one marker beat
    send('0);
    beat("zero", 0, 0, 1, 1);
    chk_idle("zero_done");

    // 8'hFF with index 1 stalled for 3 cycles
    send(N'(8'hFF));
    beat("ff_0", 0, 0, 0, 0);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) beat("ff_hold", 1, 1, 0, 0);
    outReady = 1'b1;
    beat("ff_1", 1, 1, 0, 0);
    for (int i = 2; i < 8; i++) beat("ff_n", i, i, i == 7, 0);
    chk_idle("ff_done");

    // async reset in the middle of 8'h81
    send(N'(8'h81));
    chk("r81.index0", 32'(outIndex), 0);
    chk("r81.valid0", 32'(outValid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("r81.rst");
    chk("r81.rst.index", 32'(outIndex), 0);
    chk("r81.rst.ord",   32'(outOrdinal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("r81.after");
    send(N'(8'h10));
    beat("x10", 4, 0, 1, 0);
    chk_idle("x10_done");

    // randomized bitsets against a set-bit list model
    for (int t = 0; t < 1000; t++) begin
      case (t)
        0: b = '1;
        1: b = {1'b1, {(N-1){1'b0}}};
        2: b = '0;
        default: begin
          b = {$urandom, $urandom, $urandom, $urandom}
            & {$urandom, $urandom, $urandom, $urandom}
            & {$urandom, $urandom, $urandom, $urandom};
          if ($urandom_range(0, 19) == 0) b = '0;
          else if ($urandom_range(0, 19) == 0) b = {$urandom, $urandom, $urandom, $urandom};
        end
      endcase
      exp_idx.delete();
      for (int j = 0; j < N; j++) if (b[j]) exp_idx.push_back(j);

      inValid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(b);

      k = 0; cyc = 0; fin = 0;
      while (!fin && cyc < 1000) begin
        outReady = ($urandom_range(0, 3) != 0);
        if (outValid && outReady) begin
          if (exp_idx.size() == 0) begin
            chk("rnd.e.index", 32'(outIndex), 0);
            chk("rnd.e.ord",   32'(outOrdinal), 0);
            chk("rnd.e.last",  32'(outLast), 1);
            chk("rnd.e.empty", 32'(outEmpty), 1);
          end else begin
            chk("rnd.index", 32'(outIndex), (k < exp_idx.size()) ? 32'(exp_idx[k]) : 32'hFFFF_FFFF);
            chk("rnd.ord",   32'(outOrdinal), 32'(k));
            chk("rnd.last",  32'(outLast), 32'(k == exp_idx.size() - 1));
            chk("rnd.empty", 32'(outEmpty), 0);
          end
          if (outLast || k > N) fin = 1;
          k++;
        end
        @(negedge clk);
        cyc++;
      end
      chk("rnd.finished", 32'(fin), 1);
      chk("rnd.beats", 32'(k), (exp_idx.size() == 0) ? 1 : 32'(exp_idx.size()));
      chk("rnd.idle", 32'(outValid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/set_bit_serializer.md
# set_bit_serializer

Expands a bitset into a stream of the indices of its set bits, lowest index first, one index per clock. It is the inverse direction of the popcount tree: popcount compresses a bitset to a count, while this block enumerates the members. The number of non-empty beats it emits equals the popcount of the input. It sits between producers of `1<<ORDER`-bit bitsets and consumers that process one element at a time, for example per-variable iteration over monotone-function sets.

## Interface
Parameters:
- `ORDER`, default 7: input bitset width is `1<<ORDER` bits; indices are `ORDER` bits wide.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `inBitset`  in  `1<<ORDER`  bitset to serialize; sampled only on input handshake.
- `inValid`  in  1  producer has a bitset.
- `inReady`  out  1  block can accept a bitset.
- `outIndex`  out  `ORDER`  index of the current set bit.
- `outOrdinal`  out  `ORDER+1`  sequence number of the current beat within the bitset, counting from 0.
- `outLast`  out  1  current beat is the final beat for this bitset.
- `outEmpty`  out  1  input bitset was all-zero; only set on a single marker beat.
- `outValid`  out  1  the output beat is valid.
- `outReady`  in  1  consumer accepts the beat.

## Operation
- States:
  - IDLE: `inReady`=1, `outValid`=0.
  - EMIT: `inReady`=0, `outValid`=1.
- `inReady` is decoded directly from state (IDLE).
- Internal `mask` register (`1<<ORDER` bits) holds the set bits not yet emitted.
- Input handshake (`inValid && inReady`) in IDLE, with `b` = `inBitset`:
  - If `b` != 0: `outIndex` = lowest set bit of `b`, `mask` = `b` with that bit cleared, `outOrdinal`=0, `outLast` = (`mask` == 0), `outEmpty`=0. Go to EMIT.
  - If `b` == 0: `outIndex`=0, `outOrdinal`=0, `outLast`=1, `outEmpty`=1. Go to EMIT.
- Output handshake (`outValid && outReady`) in EMIT:
  - If not `outLast`: load `outIndex` = lowest set bit of `mask`, clear that bit in `mask`, increment `outOrdinal`, set `outLast` = (new `mask` == 0). Stay in EMIT.
  - If `outLast`: go to IDLE, clear `outValid`, `outLast` and `outEmpty`. `outIndex` and `outOrdinal` may hold their values.
- While `outValid && !outReady`, all `out*` signals are held stable.
- Priority encoding is lowest index first. Width rules:
  - `outOrdinal` never exceeds `(1<<ORDER)-1`.
  - `outOrdinal`+1 on the last beat equals popcount(`b`) for non-empty input.
- An empty input produces exactly one beat, with `outEmpty`=1 and `outLast`=1.
- `inBitset` is don't-care outside the input handshake.

## Timing
- Reset, applied asynchronously and taking effect immediately:
  - state = IDLE, `mask`=0.
  - `outValid`=0, `outIndex`=0, `outOrdinal`=0, `outLast`=0, `outEmpty`=0.
  - `inReady`=1 from the first cycle after `rst_n` deasserts.
- Reset asserted mid-stream: the remaining beats are discarded and `outValid` falls without waiting for a clock edge. No partial stream resumes after reset.
- Latency: input accepted at edge t gives first beat valid after edge t (visible in cycle t+1).
- Throughput: with `outReady` held high, one beat per cycle with no gaps. A bitset with k set bits occupies k cycles in EMIT (1 cycle if empty).
- After the last-beat handshake at edge t, `inReady`=1 in cycle t+1. The next input can be accepted at edge t+1, so back-to-back bitsets see one bubble cycle.
- Outputs are all registered; `inReady` depends only on state. There is no combinational path from `outReady` or `inValid` to any output.

## Test plan
- `ORDER`=3, `inBitset`=8'b1010_0100, `outReady`=1 -> beats (index, ordinal, last):
  - (2, 0, 0), (5, 1, 0), (7, 2, 1) on consecutive cycles.
  - `inReady` is 1 again the cycle after the last beat.
- `ORDER`=3, `inBitset`=0 -> a single beat with `outEmpty`=1, `outLast`=1, `outIndex`=0, `outOrdinal`=0, then IDLE.
- `ORDER`=3, `inBitset`=8'hFF, and `outReady` low for 3 cycles while beat index 1 is presented:
  - Index 1, ordinal 1 is held stable for all 4 cycles.
  - Then indices 2..7 follow, with last on 7 and ordinal 7.
- `ORDER`=3, `inBitset`=8'h81, `rst_n` pulsed low while index 0 is presented:
  - `outValid`=0 immediately and all outputs at their reset values.
  - A new input 8'h10 afterwards yields a single beat (4, 0, last=1).
- `ORDER`=7, 1000 random bitsets including all-ones, one-hot bit 127 and all-zero, with random `inValid`/`outReady`:
  - The emitted indices match the set-bit list of a reference model for every bitset.
  - For non-empty inputs the beat count equals popcount.
  - All-ones yields 128 beats, with last at ordinal 127.
